// File: rtl/rc4_pkg.sv
// Shared constants for the RC4 key-search slice: device-select codes, sequencer
// state encoding and the printable-plaintext character range.
package rc4_pkg;

    localparam logic [5:0] MODE_IDLE    = 6'b000_000;
    localparam logic [5:0] MODE_INIT    = 6'b001_000;
    localparam logic [5:0] MODE_SHUFFLE = 6'b010_000;
    localparam logic [5:0] MODE_DECRYPT = 6'b011_000;

    localparam logic [7:0] CHAR_LO    = 8'h61;
    localparam logic [7:0] CHAR_HI    = 8'h7A;
    localparam logic [7:0] CHAR_SPACE = 8'h20;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        INIT      = 4'd1,
        GAP_I     = 4'd2,
        SHUF      = 4'd3,
        GAP_S     = 4'd4,
        DECR      = 4'd5,
        EVAL      = 4'd6,
        DONE_OK   = 4'd7,
        DONE_FAIL = 4'd8
    } search_state_e;

    function automatic logic [5:0] mode_of(input search_state_e s);
        case (s)
            INIT:    mode_of = MODE_INIT;
            SHUF:    mode_of = MODE_SHUFFLE;
            DECR:    mode_of = MODE_DECRYPT;
            default: mode_of = MODE_IDLE;
        endcase
    endfunction

    function automatic logic busy_of(input search_state_e s);
        case (s)
            IDLE, DONE_OK, DONE_FAIL: busy_of = 1'b0;
            default:                  busy_of = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/plaintext_checker.sv
// Flags any written plaintext byte outside lowercase a..z or space; the flag
// stays set until cleared for the next candidate key.
module plaintext_checker
    import rc4_pkg::*;
#(
    parameter int RAM_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 enable,
    input  logic                 aWren,
    input  logic [RAM_WIDTH-1:0] aIn,
    output logic                 bad
);

    localparam logic [RAM_WIDTH-1:0] LO_W    = RAM_WIDTH'(CHAR_LO);
    localparam logic [RAM_WIDTH-1:0] HI_W    = RAM_WIDTH'(CHAR_HI);
    localparam logic [RAM_WIDTH-1:0] SPACE_W = RAM_WIDTH'(CHAR_SPACE);

    logic byte_bad_s;

    // classify the byte currently presented on the write port
    always_comb begin
        byte_bad_s = 1'b1;
        if (((aIn >= LO_W) && (aIn <= HI_W)) || (aIn == SPACE_W)) begin
            byte_bad_s = 1'b0;
        end else begin
            byte_bad_s = 1'b1;
        end
    end

    // sticky bad flag, cleared between candidate keys
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bad <= 1'b0;
        end else if (clear) begin
            bad <= 1'b0;
        end else if (enable && aWren && byte_bad_s) begin
            bad <= 1'b1;
        end
    end

endmodule

// File: rtl/key_search_sequencer.sv
// Brute-force RC4 key search: steps each candidate key through init, shuffle and
// decrypt devices and checks the plaintext. Define ATTEMPT_COUNT_EN to add the
// attempts counter port.
module key_search_sequencer
    import rc4_pkg::*;
#(
    parameter int RAM_WIDTH   = 8,
    parameter int KEY_LENGTH  = 3,
    parameter int KEY_BITS    = 22,
    parameter int NUM_DEVICES = 3
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             abort,
    input  logic [NUM_DEVICES-1:0]           finish_bus,
    input  logic                             aWren,
    input  logic [RAM_WIDTH-1:0]             aIn,
    output logic [5:0]                       mode,
    output logic [KEY_LENGTH*RAM_WIDTH-1:0]  key,
    output logic                             busy,
    output logic                             found,
    output logic                             exhausted,
    output logic [KEY_LENGTH*RAM_WIDTH-1:0]  found_key
`ifdef ATTEMPT_COUNT_EN
    ,
    output logic [KEY_BITS:0]                attempts
`endif
);

    localparam int KW = KEY_LENGTH * RAM_WIDTH;
    localparam logic [KEY_BITS-1:0] KEY_MAX = {KEY_BITS{1'b1}};

    search_state_e   state_r, state_s;
    logic [KW-1:0]   key_r, key_s;
    logic [KW-1:0]   found_key_r, found_key_s;
    logic            found_r, found_s;
    logic            exhausted_r, exhausted_s;
    logic [5:0]      mode_r;
    logic            busy_r;
    logic            clear_s;
    logic            bad_r;

    plaintext_checker #(.RAM_WIDTH(RAM_WIDTH)) u_checker (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear_s),
        .enable (state_r == DECR),
        .aWren  (aWren),
        .aIn    (aIn),
        .bad    (bad_r)
    );

    // next-state and result bookkeeping; abort overrides everything
    always_comb begin
        state_s     = state_r;
        key_s       = key_r;
        found_key_s = found_key_r;
        found_s     = found_r;
        exhausted_s = exhausted_r;
        clear_s     = 1'b0;
        if (abort) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE, DONE_OK, DONE_FAIL: begin
                    if (start) begin
                        state_s     = INIT;
                        key_s       = {KW{1'b0}};
                        found_s     = 1'b0;
                        exhausted_s = 1'b0;
                        clear_s     = 1'b1;
                    end else begin
                        state_s = state_r;
                    end
                end
                INIT:  state_s = finish_bus[0] ? GAP_I : INIT;
                GAP_I: state_s = SHUF;
                SHUF:  state_s = finish_bus[1] ? GAP_S : SHUF;
                GAP_S: state_s = DECR;
                DECR:  state_s = finish_bus[2] ? EVAL : DECR;
                EVAL: begin
                    if (!bad_r) begin
                        state_s     = DONE_OK;
                        found_s     = 1'b1;
                        found_key_s = key_r;
                    end else if (key_r[KEY_BITS-1:0] == KEY_MAX) begin
                        state_s     = DONE_FAIL;
                        exhausted_s = 1'b1;
                    end else begin
                        state_s                = INIT;
                        key_s[KEY_BITS-1:0]    = key_r[KEY_BITS-1:0] + KEY_BITS'(1'b1);
                        clear_s                = 1'b1;
                    end
                end
                default: state_s = IDLE;
            endcase
        end
    end

    // state and registered outputs; mode/busy decoded from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            key_r       <= {KW{1'b0}};
            found_key_r <= {KW{1'b0}};
            found_r     <= 1'b0;
            exhausted_r <= 1'b0;
            mode_r      <= MODE_IDLE;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            key_r       <= key_s;
            found_key_r <= found_key_s;
            found_r     <= found_s;
            exhausted_r <= exhausted_s;
            mode_r      <= mode_of(state_s);
            busy_r      <= busy_of(state_s);
        end
    end

    assign mode      = mode_r;
    assign key       = key_r;
    assign busy      = busy_r;
    assign found     = found_r;
    assign exhausted = exhausted_r;
    assign found_key = found_key_r;

`ifdef ATTEMPT_COUNT_EN
    localparam logic [KEY_BITS:0] ATT_MAX = {(KEY_BITS+1){1'b1}};
    logic [KEY_BITS:0] attempts_r;

    // saturating count of evaluated keys since the last accepted start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            attempts_r <= {(KEY_BITS+1){1'b0}};
        end else if (start && !abort && !busy_r) begin
            attempts_r <= {(KEY_BITS+1){1'b0}};
        end else if ((state_r == EVAL) && (attempts_r != ATT_MAX)) begin
            attempts_r <= attempts_r + {{KEY_BITS{1'b0}}, 1'b1};
        end
    end

    assign attempts = attempts_r;
`endif

endmodule

// File: tb/tb_key_search_sequencer.sv
// Scoreboard bench for key_search_sequencer (KEY_BITS=4) with behavioural
// init/shuffle/decrypt device models.
module tb_key_search_sequencer;

    localparam int RW = 8;
    localparam int KL = 3;
    localparam int KB = 4;
    localparam int ND = 3;
    localparam int KW = KL * RW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [ND-1:0] finish_bus;
    logic          aWren;
    logic [RW-1:0] aIn;
    logic [5:0]    mode;
    logic [KW-1:0] key;
    logic          busy;
    logic          found;
    logic          exhausted;
    logic [KW-1:0] found_key;
`ifdef ATTEMPT_COUNT_EN
    logic [KB:0]   attempts;
`endif

    always #5 clk = ~clk;

    key_search_sequencer #(
        .RAM_WIDTH(RW), .KEY_LENGTH(KL), .KEY_BITS(KB), .NUM_DEVICES(ND)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .finish_bus(finish_bus), .aWren(aWren), .aIn(aIn),
        .mode(mode), .key(key), .busy(busy), .found(found),
        .exhausted(exhausted), .found_key(found_key)
`ifdef ATTEMPT_COUNT_EN
        , .attempts(attempts)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    typedef struct {
        logic          found;
        logic          exh;
        logic [KW-1:0] fk;
        logic [KW-1:0] key;
        logic [KB:0]   att;
    } exp_t;
    typedef struct {
        logic [5:0] mode;
        int         len;
    } run_t;

    exp_t exp_q[$];
    run_t run_q[$];

    // device models: finish pulses after fixed latency, spurious other bits as noise
    int         pattern = 0;
    int         cnt = 0;
    logic [5:0] prev_mode = 6'b000_000;

    function automatic logic [7:0] byte_for(input int pat, input logic [KW-1:0] k, input int c);
        case (pat)
            0: byte_for = 8'h61;
            1: begin
                if (k == 24'd5) byte_for = (c == 1) ? 8'h7A : ((c == 2) ? 8'h20 : 8'h61);
                else            byte_for = k[0] ? 8'h60 : 8'h41;
            end
            2: byte_for = 8'h7B;
            3: byte_for = ((k == 24'd0) && (c == 3)) ? 8'h7B : 8'h61;
            default: byte_for = 8'h00;
        endcase
    endfunction

    initial begin
        finish_bus = 3'b000;
        aWren      = 1'b0;
        aIn        = 8'h00;
        forever begin
            @(negedge clk);
            if (mode !== prev_mode) cnt = 0;
            else cnt++;
            prev_mode  = mode;
            finish_bus = 3'b000;
            aWren      = 1'b0;
            aIn        = 8'h00;
            case (mode)
                6'b001_000: begin
                    if (cnt == 1) finish_bus = 3'b110;
                    if (cnt == 3) finish_bus = 3'b001;
                end
                6'b010_000: begin
                    if (cnt == 2) finish_bus = 3'b101;
                    if (cnt == 4) finish_bus = 3'b010;
                end
                6'b011_000: begin
                    if (cnt >= 1 && cnt <= 3) begin
                        aWren = 1'b1;
                        aIn   = byte_for(pattern, key, cnt);
                    end
                    if (cnt == 2) finish_bus = 3'b011;
                    if (cnt == 3) finish_bus = 3'b100;
                end
                default: ;
            endcase
        end
    end

    // mode run-length monitor
    logic [5:0] cur_mode = 6'b000_000;
    int         cur_len = 0;
    bit         run_valid = 1'b0;
    bit         run_chk_en = 1'b0;
    run_t       run_r;

    always @(negedge clk) begin
        if (mode !== cur_mode) begin
            if (run_valid && run_q.size() > 0) begin
                run_r = run_q.pop_front();
                check("run_mode", 32'(cur_mode), 32'(run_r.mode));
                check("run_len", cur_len, run_r.len);
            end
            cur_mode  = mode;
            cur_len   = 1;
            run_valid = run_chk_en;
        end else begin
            cur_len++;
        end
    end

    // completion monitor: each busy falling edge pops one expected result
    logic prev_busy = 1'b0;
    exp_t exp_r;

    always @(negedge clk) begin
        if (prev_busy && !busy) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=busy_fall required=none");
            end else begin
                exp_r = exp_q.pop_front();
                check("done_found", 32'(found), 32'(exp_r.found));
                check("done_exhausted", 32'(exhausted), 32'(exp_r.exh));
                check("done_found_key", 32'(found_key), 32'(exp_r.fk));
                check("done_key", 32'(key), 32'(exp_r.key));
                check("done_mode", 32'(mode), 32'(6'b000_000));
`ifdef ATTEMPT_COUNT_EN
                check("done_attempts", 32'(attempts), 32'(exp_r.att));
`endif
            end
        end
        prev_busy = busy;
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            failures++;
            $display("FAIL wait_idle actual=busy required=idle");
        end
    endtask

    task automatic wait_for(input logic [5:0] m, input logic [KW-1:0] k);
        int n = 0;
        while (!(mode === m && key === k) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            failures++;
            $display("FAIL wait_for actual=mode 0x%0h key 0x%0h required=mode 0x%0h key 0x%0h", mode, key, m, k);
        end
    endtask

    task automatic run_search(input int pat, input logic f, input logic x,
                              input logic [KW-1:0] fk, input logic [KW-1:0] k, input logic [KB:0] a);
        exp_t e;
        e.found = f; e.exh = x; e.fk = fk; e.key = k; e.att = a;
        pattern = pat;
        exp_q.push_back(e);
        pulse_start();
        wait_idle();
    endtask

    initial begin
        exp_t e;
        run_t r;
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mode", 32'(mode), 32'(6'b000_000));
        check("rst_key", 32'(key), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_found", 32'(found), 32'd0);
        check("rst_exhausted", 32'(exhausted), 32'd0);
        check("rst_found_key", 32'(found_key), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // key 0 decrypts cleanly; also checks per-key mode sequence
        r.mode = 6'b001_000; r.len = 4; run_q.push_back(r);
        r.mode = 6'b000_000; r.len = 1; run_q.push_back(r);
        r.mode = 6'b010_000; r.len = 5; run_q.push_back(r);
        r.mode = 6'b000_000; r.len = 1; run_q.push_back(r);
        r.mode = 6'b011_000; r.len = 4; run_q.push_back(r);
        run_chk_en = 1'b1;
        run_search(0, 1'b1, 1'b0, 24'h000000, 24'h000000, 5'd1);
        run_chk_en = 1'b0;

        // only key 5 yields valid text (0x7A / 0x20 / 0x61 boundaries)
        run_search(1, 1'b1, 1'b0, 24'h000005, 24'h000005, 5'd6);

        // asynchronous reset in the middle of a shuffle at key 2
        e.found = 1'b0; e.exh = 1'b0; e.fk = 24'h0; e.key = 24'h0; e.att = 5'd0;
        exp_q.push_back(e);
        pattern = 2;
        pulse_start();
        wait_for(6'b010_000, 24'h000002);
        #2 reset = 1'b1;
        #1;
        check("midrst_mode", 32'(mode), 32'(6'b000_000));
        check("midrst_key", 32'(key), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_found_key", 32'(found_key), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // no valid key: exhaust at 0xF without wrapping
        run_search(2, 1'b0, 1'b1, 24'h000000, 24'h00000F, 5'd16);

        // bad byte coinciding with decrypt finish must reject key 0
        run_search(3, 1'b1, 1'b0, 24'h000001, 24'h000001, 5'd2);

        // abort and start together during decrypt at key 1
        e.found = 1'b0; e.exh = 1'b0; e.fk = 24'h000001; e.key = 24'h000001; e.att = 5'd1;
        exp_q.push_back(e);
        pattern = 2;
        pulse_start();
        wait_for(6'b011_000, 24'h000001);
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_mode", 32'(mode), 32'(6'b000_000));
        repeat (3) @(negedge clk);
        check("abort_stays_idle", 32'(busy), 32'd0);

        // fresh start after abort begins again at key 0
        run_search(0, 1'b1, 1'b0, 24'h000000, 24'h000000, 5'd1);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        check("runs_drained", run_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
